// File: rtl/ray_dispatcher_pkg.sv
// Shared types and constants for the ray dispatcher and its direction generator.
// Colour constants, 28-bit vector field layout and FSM state encoding.
package ray_dispatcher_pkg;

    localparam logic [11:0] BLACK = 12'h000;
    localparam logic [11:0] WHITE = 12'hFFF;

    localparam int VEC_W = 28;
    localparam int X_MSB = 27;
    localparam int X_LSB = 18;
    localparam int Y_MSB = 17;
    localparam int Y_LSB = 8;
    localparam int Z_MSB = 7;
    localparam int Z_LSB = 0;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] z;
    } vec_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_WRITE,
        ST_DONE
    } state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ray_dispatcher_dir_gen.sv
// Registered pixel (col,row) to screen-centred primary ray direction {dx, dy, FOCAL}.
// One cycle latency from load_i; output holds while load_i is low, no backpressure.
module ray_dir_gen
    import ray_dispatcher_pkg::*;
#(
    parameter int         H_RES = 640,
    parameter int         V_RES = 480,
    parameter logic [7:0] FOCAL = 8'd200
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [9:0]       col_i,
    input  logic [9:0]       row_i,
    output logic [VEC_W-1:0] ray_dir_o
);

    // 10-bit modular subtraction gives the same low bits as the 11-bit signed
    // difference truncated to 10 bits, so the extra sign bit is never built.
    localparam logic [9:0] HALF_H = 10'(H_RES / 2);
    localparam logic [9:0] CTR_V  = 10'(V_RES / 2 - 1);

    logic [VEC_W-1:0] ray_dir_q;
    logic [9:0]       dx;
    logic [9:0]       dy;

    assign dx = col_i - HALF_H;
    assign dy = CTR_V - row_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ray_dir_q <= '0;
        end else if (load_i) begin
            ray_dir_q[X_MSB:X_LSB] <= dx;
            ray_dir_q[Y_MSB:Y_LSB] <= dy;
            ray_dir_q[Z_MSB:Z_LSB] <= FOCAL;
        end
    end

    assign ray_dir_o = ray_dir_q;

endmodule

// File: rtl/ray_dispatcher.sv
// Raster-order primary ray issue, tracer result capture and frame buffer write.
// Per pixel: ISSUE + WAIT (until tracer_ret or TIMEOUT cycles) + WRITE; start ignored while busy.
module ray_dispatcher
    import ray_dispatcher_pkg::*;
#(
    parameter int         H_RES   = 640,
    parameter int         V_RES   = 480,
    parameter logic [7:0] FOCAL   = 8'd200,
    parameter int         TIMEOUT = 64,
    parameter int         ADDR_W  = 19
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [27:0]       cam_pos_i,
    output logic [27:0]       ray_init_o,
    output logic [27:0]       ray_dir_o,
    output logic              ray_valid_o,
    input  logic              tracer_ret_i,
    input  logic [11:0]       tracer_color_i,
    output logic              fb_we_o,
    output logic [ADDR_W-1:0] fb_addr_o,
    output logic [11:0]       fb_data_o,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic [15:0]       timeout_cnt_o
);

    localparam logic [9:0]  LAST_COL  = 10'(H_RES - 1);
    localparam logic [9:0]  LAST_ROW  = 10'(V_RES - 1);
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [9:0]        col_q, col_d;
    logic [9:0]        row_q, row_d;
    logic [ADDR_W-1:0] pix_q, pix_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [11:0]       fb_data_q, fb_data_d;
    vec_t              ray_init_q, ray_init_d;
    logic              ray_valid_q, ray_valid_d;
    logic [15:0]       wait_q, wait_d;
    logic [15:0]       timeout_q, timeout_d;
    logic              dir_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            pix_q       <= '0;
            fb_addr_q   <= '0;
            fb_data_q   <= '0;
            ray_init_q  <= '0;
            ray_valid_q <= 1'b0;
            wait_q      <= '0;
            timeout_q   <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            pix_q       <= pix_d;
            fb_addr_q   <= fb_addr_d;
            fb_data_q   <= fb_data_d;
            ray_init_q  <= ray_init_d;
            ray_valid_q <= ray_valid_d;
            wait_q      <= wait_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        pix_d       = pix_q;
        fb_addr_d   = fb_addr_q;
        fb_data_d   = fb_data_q;
        ray_init_d  = ray_init_q;
        ray_valid_d = ray_valid_q;
        wait_d      = wait_q;
        timeout_d   = timeout_q;
        dir_load    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    ray_init_d = vec_t'(cam_pos_i);
                    col_d      = '0;
                    row_d      = '0;
                    pix_d      = '0;
                    timeout_d  = '0;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                dir_load    = 1'b1;
                ray_valid_d = 1'b1;
                wait_d      = '0;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                wait_d = wait_q + 16'd1;
                // A return in the final timeout cycle still counts as a real result.
                if (tracer_ret_i) begin
                    fb_data_d   = tracer_color_i;
                    fb_addr_d   = pix_q;
                    ray_valid_d = 1'b0;
                    state_d     = ST_WRITE;
                end else if (wait_q == WAIT_LAST) begin
                    fb_data_d   = BLACK;
                    fb_addr_d   = pix_q;
                    timeout_d   = sat_inc16(timeout_q);
                    ray_valid_d = 1'b0;
                    state_d     = ST_WRITE;
                end
            end
            ST_WRITE: begin
                pix_d = pix_q + ADDR_W'(1);
                if (col_q == LAST_COL) begin
                    col_d = '0;
                    row_d = row_q + 10'd1;
                end else begin
                    col_d = col_q + 10'd1;
                end
                if (col_q == LAST_COL && row_q == LAST_ROW) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    ray_dir_gen #(
        .H_RES (H_RES),
        .V_RES (V_RES),
        .FOCAL (FOCAL)
    ) u_dir_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (dir_load),
        .col_i     (col_q),
        .row_i     (row_q),
        .ray_dir_o (ray_dir_o)
    );

    assign ray_init_o    = ray_init_q;
    assign ray_valid_o   = ray_valid_q;
    assign fb_we_o       = (state_q == ST_WRITE);
    assign fb_addr_o     = fb_addr_q;
    assign fb_data_o     = fb_data_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign frame_done_o  = (state_q == ST_DONE);
    assign timeout_cnt_o = timeout_q;

endmodule

// File: tb/tb_ray_dispatcher.sv
// Directed bench for ray_dispatcher on a 4x2 screen with TIMEOUT=8, plus a 640x480 direction unit check.
module tb_ray_dispatcher;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int TO = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [27:0]   cam_pos = '0;
    logic [27:0]   ray_init;
    logic [27:0]   ray_dir;
    logic          ray_valid;
    logic          tracer_ret;
    logic [11:0]   tracer_color;
    logic          fb_we;
    logic [AW-1:0] fb_addr;
    logic [11:0]   fb_data;
    logic          busy;
    logic          frame_done;
    logic [15:0]   timeout_cnt;

    always #5 clk = ~clk;

    ray_dispatcher #(
        .H_RES(H), .V_RES(V), .FOCAL(8'd200), .TIMEOUT(TO), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .cam_pos_i(cam_pos),
        .ray_init_o(ray_init), .ray_dir_o(ray_dir), .ray_valid_o(ray_valid),
        .tracer_ret_i(tracer_ret), .tracer_color_i(tracer_color),
        .fb_we_o(fb_we), .fb_addr_o(fb_addr), .fb_data_o(fb_data),
        .busy_o(busy), .frame_done_o(frame_done), .timeout_cnt_o(timeout_cnt)
    );

    logic        dg_load = 1'b0;
    logic [9:0]  dg_col = '0;
    logic [9:0]  dg_row = '0;
    logic [27:0] dg_dir;

    ray_dir_gen #(.H_RES(640), .V_RES(480), .FOCAL(8'd200)) u_dg (
        .clk(clk), .rst_n(rst_n), .load_i(dg_load),
        .col_i(dg_col), .row_i(dg_row), .ray_dir_o(dg_dir)
    );

    // Tracer model: returns once ray_valid has been high for ret_at cycles.
    int          ret_at = 3;
    int          vcnt;
    logic [11:0] tcol = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)         vcnt <= 0;
        else if (ray_valid) vcnt <= vcnt + 1;
        else                vcnt <= 0;
    end
    assign tracer_ret   = ray_valid && (vcnt == ret_at);
    assign tracer_color = tcol;

    int          cyc = 0;
    int          w_addr[$];
    logic [11:0] w_data[$];
    int          w_cyc[$];
    logic [27:0] dirs[$];
    int          fd_cnt = 0;
    logic        rv_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fb_we) begin
            w_addr.push_back(int'(fb_addr));
            w_data.push_back(fb_data);
            w_cyc.push_back(cyc);
        end
        if (frame_done) fd_cnt = fd_cnt + 1;
        if (ray_valid && !rv_prev) dirs.push_back(ray_dir);
        rv_prev = ray_valid;
    end

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic bound_fail(input string nm);
        nvec++;
        nerr++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    task automatic run_frame(input int ra, input logic [11:0] c, input logic [27:0] cp, output int meas);
        int s;
        w_addr.delete(); w_data.delete(); w_cyc.delete(); dirs.delete();
        fd_cnt = 0;
        ret_at = ra;
        tcol   = c;
        @(negedge clk);
        start = 1'b1;
        cam_pos = cp;
        @(negedge clk);
        start = 1'b0;
        s = cyc;
        meas = -1;
        for (int k = 0; k < 2000; k++) begin
            if (frame_done) begin
                meas = cyc - s;
                break;
            end
            @(negedge clk);
        end
        if (meas < 0) bound_fail("frame_done wait");
        repeat (2) @(negedge clk);
    endtask

    task automatic check_frame(input string tag, input logic [11:0] ed, input logic [15:0] eto,
                               input int ecyc, input int meas);
        logic [9:0]  edx, edy;
        logic [27:0] edir;
        chk({tag, " frame_cycles"}, meas, ecyc);
        chk({tag, " write_count"}, w_addr.size(), H * V);
        chk({tag, " frame_done_pulses"}, fd_cnt, 1);
        chk({tag, " timeout_cnt"}, timeout_cnt, eto);
        chk({tag, " busy_after"}, busy, 1'b0);
        for (int i = 0; i < w_addr.size() && i < H * V; i++) begin
            chk($sformatf("%s addr[%0d]", tag, i), w_addr[i], i);
            chk($sformatf("%s data[%0d]", tag, i), w_data[i], ed);
            if (i > 0) chk($sformatf("%s gap[%0d]", tag, i), w_cyc[i] - w_cyc[i-1], ecyc / (H * V));
        end
        chk({tag, " dir_count"}, dirs.size(), H * V);
        for (int i = 0; i < dirs.size() && i < H * V; i++) begin
            edx  = 10'(i % H) - 10'(H / 2);
            edy  = 10'(V / 2 - 1) - 10'(i / H);
            edir = {edx, edy, 8'd200};
            chk($sformatf("%s dir[%0d]", tag, i), dirs[i], edir);
        end
    endtask

    typedef struct {
        int          ret_at;
        logic [11:0] color;
        logic [11:0] exp_data;
        logic [15:0] exp_to;
        int          exp_cyc;
    } fvec_t;

    fvec_t tbl[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int meas;
        logic [27:0] cp;

        tbl[0] = '{3,   12'hFFF, 12'hFFF, 16'd0, 48};
        tbl[1] = '{999, 12'h123, 12'h000, 16'd8, 80};
        tbl[2] = '{7,   12'hABC, 12'hABC, 16'd0, 80};
        tbl[3] = '{0,   12'h5A5, 12'h5A5, 16'd0, 24};
        tbl[4] = '{6,   12'h0F0, 12'h0F0, 16'd0, 72};

        #3;
        chk("reset ray_init", ray_init, 0);
        chk("reset ray_dir", ray_dir, 0);
        chk("reset ray_valid", ray_valid, 0);
        chk("reset fb_we", fb_we, 0);
        chk("reset fb_addr", fb_addr, 0);
        chk("reset fb_data", fb_data, 0);
        chk("reset busy", busy, 0);
        chk("reset frame_done", frame_done, 0);
        chk("reset timeout_cnt", timeout_cnt, 0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        // 640x480 direction mapping, including both screen corners.
        @(negedge clk); dg_col = 10'd0;   dg_row = 10'd0;   dg_load = 1'b1;
        @(negedge clk); chk("dg640 (0,0)", dg_dir, {10'h2C0, 10'd239, 8'd200});
        dg_col = 10'd639; dg_row = 10'd479;
        @(negedge clk); chk("dg640 (639,479)", dg_dir, {10'd319, 10'h310, 8'd200});
        dg_col = 10'd320; dg_row = 10'd240;
        @(negedge clk); chk("dg640 (320,240)", dg_dir, {10'd0, 10'h3FF, 8'd200});
        dg_load = 1'b0; dg_col = 10'd5;
        @(negedge clk); chk("dg640 hold", dg_dir, {10'd0, 10'h3FF, 8'd200});

        for (int i = 0; i < 5; i++) begin
            cp = 28'h1234560 + 28'(i);
            run_frame(tbl[i].ret_at, tbl[i].color, cp, meas);
            check_frame($sformatf("vec%0d", i), tbl[i].exp_data, tbl[i].exp_to, tbl[i].exp_cyc, meas);
            chk($sformatf("vec%0d ray_init", i), ray_init, cp);
        end

        // start pulsed mid-frame must be ignored.
        fork
            run_frame(3, 12'h3C3, 28'hA5A5A5A, meas);
            begin
                repeat (20) @(negedge clk);
                chk("midstart busy", busy, 1'b1);
                start = 1'b1;
                cam_pos = 28'h0F0F0F0;
                @(negedge clk);
                start = 1'b0;
            end
        join
        check_frame("midstart", 12'h3C3, 16'd0, 48, meas);
        chk("midstart ray_init", ray_init, 28'hA5A5A5A);

        // Async reset while waiting on pixel 5 of a timing-out frame.
        w_addr.delete(); w_data.delete(); w_cyc.delete(); dirs.delete();
        ret_at = 999;
        tcol = 12'h111;
        @(negedge clk); start = 1'b1; cam_pos = 28'h7654321;
        @(negedge clk); start = 1'b0;
        begin
            int k;
            for (k = 0; k < 1000 && w_addr.size() < 5; k++) @(negedge clk);
            if (w_addr.size() < 5) bound_fail("reset test write 5 wait");
            for (k = 0; k < 50 && !ray_valid; k++) @(negedge clk);
            if (!ray_valid) bound_fail("reset test ray_valid wait");
        end
        chk("rst pre timeout_cnt", timeout_cnt, 5);
        chk("rst pre busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst mid ray_init", ray_init, 0);
        chk("rst mid ray_dir", ray_dir, 0);
        chk("rst mid ray_valid", ray_valid, 0);
        chk("rst mid fb_we", fb_we, 0);
        chk("rst mid fb_addr", fb_addr, 0);
        chk("rst mid fb_data", fb_data, 0);
        chk("rst mid busy", busy, 0);
        chk("rst mid frame_done", frame_done, 0);
        chk("rst mid timeout_cnt", timeout_cnt, 0);
        repeat (5) @(negedge clk);
        chk("rst no further writes", w_addr.size(), 5);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_frame(3, 12'h777, 28'h0ABCDEF, meas);
        check_frame("post_reset", 12'h777, 16'd0, 48, meas);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
